lieat_exu_vpu_vcsr: RTL

Vector CSR file for the VPU execution cluster. It holds the architectural `vtype`, `vl`, `vstart`, `vxrm` and `vxsat` state and absorbs the `vl`/`vtype` write port driven by the vset unit. It returns the current `vl` code to that unit. It also executes Zicsr accesses to the vector CSRs through a one-entry valid/ready stage that has the same shape as the other VPU execution units.

---
 rtl/lieat_exu_vpu_vcsr_pkg.sv | 51 +++++
 rtl/lieat_exu_vpu_vcsr_if.sv | 41 ++++
 rtl/lieat_exu_vpu_vcsr_dec.sv | 62 ++++++
 rtl/lieat_general_dfflr.sv | 21 ++
 rtl/lieat_exu_vpu_vcsr.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/lieat_exu_vpu_vcsr_pkg.sv
// Shared constants and bundle types for the VPU vector CSR file.
// Addresses, Zicsr op codes and the held CSR-stage entry layout.
package lieat_exu_vpu_vcsr_pkg;

    localparam logic [11:0] VCSR_ADDR_VSTART = 12'h008;
    localparam logic [11:0] VCSR_ADDR_VXSAT  = 12'h009;
    localparam logic [11:0] VCSR_ADDR_VXRM   = 12'h00A;
    localparam logic [11:0] VCSR_ADDR_VCSR   = 12'h00F;
    localparam logic [11:0] VCSR_ADDR_VL     = 12'hC20;
    localparam logic [11:0] VCSR_ADDR_VTYPE  = 12'hC21;
    localparam logic [11:0] VCSR_ADDR_VLENB  = 12'hC22;

    localparam logic [1:0] CSR_OP_RW = 2'b01;
    localparam logic [1:0] CSR_OP_RS = 2'b10;
    localparam logic [1:0] CSR_OP_RC = 2'b11;

    localparam int          VTYPE_VILL_BIT = 31;
    localparam logic [31:0] VTYPE_VILL     = 32'h8000_0000;

    typedef struct packed {
        logic vstart;
        logic vxsat;
        logic vxrm;
        logic vcsr;
    } vcsr_sel_t;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] nval;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        wr;
        logic        illegal;
        vcsr_sel_t   sel;
    } vcsr_ent_t;

    function automatic logic [31:0] csr_newval(
        input logic [1:0]  op,
        input logic [31:0] old,
        input logic [31:0] src
    );
        logic [31:0] r;
        unique case (op)
            CSR_OP_RS: r = old | src;
            CSR_OP_RC: r = old & ~src;
            default:   r = src;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lieat_exu_vpu_vcsr_if.sv
// Valid/ready request and result bundle of the vector CSR stage.
// master drives requests and consumes results; slave is the CSR file.
interface lieat_exu_vpu_vcsr_if;

    logic        csr_i_valid;
    logic        csr_i_ready;
    logic [11:0] csr_i_addr;
    logic [1:0]  csr_i_op;
    logic        csr_i_wr;
    logic [31:0] csr_i_src1;
    logic [4:0]  csr_i_rd;
    logic [31:0] csr_i_pc;

    logic        csr_o_valid;
    logic        csr_o_ready;
    logic        csr_o_flush;
    logic [31:0] csr_o_data;
    logic [31:0] csr_o_pc;
    logic        csr_o_wen;
    logic [4:0]  csr_o_rd;
    logic        csr_o_illegal;

    modport master (
        output csr_i_valid, csr_i_addr, csr_i_op, csr_i_wr,
        output csr_i_src1, csr_i_rd, csr_i_pc,
        input  csr_i_ready,
        output csr_o_ready,
        input  csr_o_valid, csr_o_flush, csr_o_data, csr_o_pc,
        input  csr_o_wen, csr_o_rd, csr_o_illegal
    );

    modport slave (
        input  csr_i_valid, csr_i_addr, csr_i_op, csr_i_wr,
        input  csr_i_src1, csr_i_rd, csr_i_pc,
        output csr_i_ready,
        input  csr_o_ready,
        output csr_o_valid, csr_o_flush, csr_o_data, csr_o_pc,
        output csr_o_wen, csr_o_rd, csr_o_illegal
    );

endinterface

// File: rtl/lieat_exu_vpu_vcsr_dec.sv
// Vector CSR address decode: target select, RO/illegal check and
// the old-value read mux.
module lieat_exu_vpu_vcsr_dec
    import lieat_exu_vpu_vcsr_pkg::*;
#(
    parameter int VLENB = 4
) (
    input  logic [11:0] addr,
    input  logic        wr,
    input  logic [4:0]  vstart,
    input  logic        vxsat,
    input  logic [1:0]  vxrm,
    input  logic [31:0] vtype,
    input  logic [5:0]  vl,
    output vcsr_sel_t   sel,
    output logic        illegal,
    output logic [31:0] old
);

    logic hit_vstart;
    logic hit_vxsat;
    logic hit_vxrm;
    logic hit_vcsr;
    logic hit_vl;
    logic hit_vtype;
    logic hit_vlenb;
    logic hit_ro;
    logic hit_any;

    assign hit_vstart = (addr == VCSR_ADDR_VSTART);
    assign hit_vxsat  = (addr == VCSR_ADDR_VXSAT);
    assign hit_vxrm   = (addr == VCSR_ADDR_VXRM);
    assign hit_vcsr   = (addr == VCSR_ADDR_VCSR);
    assign hit_vl     = (addr == VCSR_ADDR_VL);
    assign hit_vtype  = (addr == VCSR_ADDR_VTYPE);
    assign hit_vlenb  = (addr == VCSR_ADDR_VLENB);

    assign hit_ro  = hit_vl | hit_vtype | hit_vlenb;
    assign hit_any = hit_ro | hit_vstart | hit_vxsat
                   | hit_vxrm | hit_vcsr;
    assign illegal = ~hit_any | (wr & hit_ro);

    assign sel.vstart = hit_vstart;
    assign sel.vxsat  = hit_vxsat;
    assign sel.vxrm   = hit_vxrm;
    assign sel.vcsr   = hit_vcsr;

    always_comb begin
        old = '0;
        unique case (1'b1)
            hit_vstart: old = {27'b0, vstart};
            hit_vxsat:  old = {31'b0, vxsat};
            hit_vxrm:   old = {30'b0, vxrm};
            hit_vcsr:   old = {29'b0, vxrm, vxsat};
            hit_vl:     old = {26'b0, vl};
            hit_vtype:  old = vtype;
            hit_vlenb:  old = 32'(VLENB);
            default:    old = '0;
        endcase
    end

endmodule

// File: rtl/lieat_general_dfflr.sv
// Load-enabled flop bank with synchronous active-low reset.
module lieat_general_dfflr #(
    parameter int            DW      = 1,
    parameter logic [DW-1:0] RST_VAL = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          lden,
    input  logic [DW-1:0] dnxt,
    output logic [DW-1:0] qout
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            qout <= RST_VAL;
        end else if (lden) begin
            qout <= dnxt;
        end
    end

endmodule

// File: rtl/lieat_exu_vpu_vcsr.sv
// Vector CSR file: vtype/vl/vstart/vxrm/vxsat state, vset write port
// and a one-entry Zicsr execution stage.
module lieat_exu_vpu_vcsr
    import lieat_exu_vpu_vcsr_pkg::*;
#(
    parameter int VLENB = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush_req,
    input  logic        vset_vtype_wen,
    input  logic [31:0] vset_vtype_wdata,
    input  logic        vset_vl_wen,
    input  logic [4:0]  vset_vl_wdata,
    output logic [4:0]  vset_vl_rdata,
    lieat_exu_vpu_vcsr_if.slave csr,
    input  logic        vpu_vxsat_set,
    input  logic        vpu_vstart_clr,
    output logic [31:0] vtype_o,
    output logic [5:0]  vl_o,
    output logic [4:0]  vstart_o,
    output logic [1:0]  vxrm_o
);

    logic        i_sh;
    logic        o_sh;
    logic        o_flush;
    logic        wr_fire;
    logic        vld_q;
    vcsr_ent_t   ent_d;
    vcsr_ent_t   ent_q;
    vcsr_sel_t   dec_sel;
    logic        dec_illegal;
    logic [31:0] dec_old;

    logic [31:0] vtype_q;
    logic [31:0] vtype_d;
    logic [4:0]  vlc_q;
    logic [4:0]  vstart_q;
    logic [4:0]  vstart_d;
    logic        vstart_ld;
    logic        vxsat_q;
    logic        vxsat_w;
    logic        vxsat_ld;
    logic [1:0]  vxrm_q;
    logic [1:0]  vxrm_d;
    logic        vxrm_ld;
    logic        vill;
    logic        unused_ok;

    lieat_exu_vpu_vcsr_dec #(
        .VLENB(VLENB)
    ) u_dec (
        .addr   (csr.csr_i_addr),
        .wr     (csr.csr_i_wr),
        .vstart (vstart_q),
        .vxsat  (vxsat_q),
        .vxrm   (vxrm_q),
        .vtype  (vtype_q),
        .vl     (vl_o),
        .sel    (dec_sel),
        .illegal(dec_illegal),
        .old    (dec_old)
    );

    assign i_sh    = csr.csr_i_valid & csr.csr_i_ready;
    assign o_sh    = vld_q & csr.csr_o_ready;
    assign o_flush = flush_req & vld_q;
    assign wr_fire = o_sh & ~o_flush & ~ent_q.illegal & ent_q.wr;

    always_comb begin
        ent_d         = '0;
        ent_d.data    = dec_old;
        ent_d.nval    = csr_newval(csr.csr_i_op, dec_old,
                                   csr.csr_i_src1);
        ent_d.pc      = csr.csr_i_pc;
        ent_d.rd      = csr.csr_i_rd;
        ent_d.wr      = csr.csr_i_wr;
        ent_d.illegal = dec_illegal;
        ent_d.sel     = dec_sel;
    end

    lieat_general_dfflr #(
        .DW($bits(vcsr_ent_t))
    ) u_ent (
        .clk  (clock),
        .rst_n(reset),
        .lden (i_sh),
        .dnxt (ent_d),
        .qout (ent_q)
    );

    // a new entry outranks the retire/flush of the previous one
    lieat_general_dfflr #(
        .DW(1)
    ) u_vld (
        .clk  (clock),
        .rst_n(reset),
        .lden (i_sh | o_sh | o_flush),
        .dnxt (i_sh),
        .qout (vld_q)
    );

    assign csr.csr_i_ready   = ~vld_q | o_sh;
    assign csr.csr_o_valid   = vld_q;
    assign csr.csr_o_flush   = o_flush;
    assign csr.csr_o_data    = ent_q.data;
    assign csr.csr_o_pc      = ent_q.pc;
    assign csr.csr_o_rd      = ent_q.rd;
    assign csr.csr_o_wen     = ~ent_q.illegal;
    assign csr.csr_o_illegal = ent_q.illegal;

    assign vill = ~($onehot(vset_vtype_wdata[8:6])
                  & $onehot(vset_vtype_wdata[5:0]));
    assign vtype_d = vill ? VTYPE_VILL
                          : {21'b0, vset_vtype_wdata[10:0]};

    lieat_general_dfflr #(
        .DW     (32),
        .RST_VAL(VTYPE_VILL)
    ) u_vtype (
        .clk  (clock),
        .rst_n(reset),
        .lden (vset_vtype_wen),
        .dnxt (vtype_d),
        .qout (vtype_q)
    );

    lieat_general_dfflr #(
        .DW(5)
    ) u_vl (
        .clk  (clock),
        .rst_n(reset),
        .lden (vset_vl_wen),
        .dnxt (vset_vl_wdata),
        .qout (vlc_q)
    );

    // CSR write beats the VPU side-band events
    assign vstart_ld = (wr_fire & ent_q.sel.vstart) | vpu_vstart_clr;
    assign vstart_d  = (wr_fire & ent_q.sel.vstart)
                     ? ent_q.nval[4:0] : 5'd0;

    lieat_general_dfflr #(
        .DW(5)
    ) u_vstart (
        .clk  (clock),
        .rst_n(reset),
        .lden (vstart_ld),
        .dnxt (vstart_d),
        .qout (vstart_q)
    );

    assign vxsat_w  = wr_fire & (ent_q.sel.vxsat | ent_q.sel.vcsr);
    assign vxsat_ld = vxsat_w | vpu_vxsat_set;

    lieat_general_dfflr #(
        .DW(1)
    ) u_vxsat (
        .clk  (clock),
        .rst_n(reset),
        .lden (vxsat_ld),
        .dnxt (vxsat_w ? ent_q.nval[0] : 1'b1),
        .qout (vxsat_q)
    );

    assign vxrm_ld = wr_fire & (ent_q.sel.vxrm | ent_q.sel.vcsr);
    assign vxrm_d  = ent_q.sel.vcsr ? ent_q.nval[2:1]
                                    : ent_q.nval[1:0];

    lieat_general_dfflr #(
        .DW(2)
    ) u_vxrm (
        .clk  (clock),
        .rst_n(reset),
        .lden (vxrm_ld),
        .dnxt (vxrm_d),
        .qout (vxrm_q)
    );

    assign vl_o = vtype_q[VTYPE_VILL_BIT] ? 6'd0
                                          : {1'b0, vlc_q} + 6'd1;
    assign vtype_o       = vtype_q;
    assign vstart_o      = vstart_q;
    assign vxrm_o        = vxrm_q;
    assign vset_vl_rdata = vlc_q;

    assign unused_ok = ^{vset_vtype_wdata[31:11], ent_q.nval[31:5]};

endmodule
